// File: rtl/dpr_reader_pkg.sv
// dpr_reader_pkg: shared types and constants for dual_port_ram_reader.
//   dpr_state_e          - transfer FSM states
//   DPR_DEFAULT_ADDR_W   - default RAM address width
//   dpr_beat_w()         - width of the remaining-beat counter for a given address width
package dpr_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    DONE
  } dpr_state_e;

  localparam int unsigned DPR_DEFAULT_ADDR_W = 10;

  // ceil(len/2) never exceeds memDepth/2, so the address width is enough for the beat count.
  function automatic int unsigned dpr_beat_w(input int unsigned addr_w);
    return addr_w;
  endfunction

endpackage

// File: rtl/dpr_reader_outbuf.sv
// dpr_reader_outbuf: 2-entry registered skid buffer for the reader output beats.
//   clk, rst  - clock, synchronous active-high reset
//   i_push    - write i_data (caller guarantees o_count < 2)
//   i_data    - packed beat {a, b, bvalid, last}
//   i_ready   - downstream accepts the head entry
//   o_valid   - head entry present
//   o_data    - head entry, straight from a flop
//   o_count   - current occupancy (0..2)
module dpr_reader_outbuf
  import dpr_reader_pkg::*;
#(
  parameter int unsigned W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      unique case (r_cnt)
        2'd0: begin
          if (i_push) begin
            r_head <= i_data;
            r_cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && w_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_skid <= i_data;
            r_cnt  <= 2'd2;
          end else if (w_pop) begin
            r_cnt <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head <= r_skid;
            r_cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dual_port_ram_reader.sv
// dual_port_ram_reader: streams a contiguous RAM region out of a two-read-port
// synchronous RAM at two words per beat with a valid/ready handshake.
//   clk, rst              - clock, synchronous active-high reset
//   start/base_addr/len   - transfer request (sampled in IDLE only)
//   busy, done            - status; done is a one-cycle pulse
//   mem_en/we/addra/addrb - RAM control (addrb = addra+1 mod memDepth, we = 0)
//   mem_doa, mem_dob      - RAM read data (one-cycle registered-address latency)
//   out_*                 - output beat stream, out_ready is backpressure
// Optional build macro DPR_READER_OUTREG_EN: registered 2-entry output buffer,
// mem_en then has no combinational path from out_ready.
module dual_port_ram_reader
  import dpr_reader_pkg::*;
#(
  parameter int unsigned addressBitWidth = DPR_DEFAULT_ADDR_W,
  parameter int unsigned dataWidth       = 16,
  parameter int unsigned memDepth        = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [addressBitWidth-1:0] base_addr,
  input  logic [addressBitWidth:0]   len,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [addressBitWidth-1:0] mem_addra,
  output logic [addressBitWidth-1:0] mem_addrb,
  input  logic [dataWidth-1:0]       mem_doa,
  input  logic [dataWidth-1:0]       mem_dob,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [dataWidth-1:0]       out_a,
  output logic [dataWidth-1:0]       out_b,
  output logic                       out_bvalid,
  output logic                       out_last
);

  localparam int unsigned AW     = addressBitWidth;
  localparam int unsigned BEAT_W = dpr_beat_w(addressBitWidth);

  dpr_state_e        r_state;
  dpr_state_e        w_state_nxt;
  logic [AW-1:0]     r_ptr;
  logic [BEAT_W-1:0] r_beats_left;
  logic              r_odd;
  logic [BEAT_W-1:0] w_beats;
  logic [AW-1:0]     w_ptr_step;
  logic              w_issue;
  logic              w_hs;
  logic              w_last_issue;
  logic              w_tag_bvalid;

  assign w_beats      = BEAT_W'(len[AW:1]) + BEAT_W'(len[0]);
  assign w_ptr_step   = AW'((32'(r_ptr) + 32'd2) % memDepth);
  assign w_last_issue = (r_beats_left == BEAT_W'(1));
  assign w_tag_bvalid = !(w_last_issue && r_odd);

  assign mem_en    = w_issue;
  assign mem_we    = 1'b0;
  assign mem_addra = r_ptr;
  assign mem_addrb = AW'((32'(r_ptr) + 32'd1) % memDepth);
  assign w_hs      = out_valid && out_ready;

`ifdef DPR_READER_OUTREG_EN
  localparam int unsigned BW = 2 * dataWidth + 2;

  logic          r_inflight;
  logic          r_if_last;
  logic          r_if_bvalid;
  logic          w_push;
  logic [1:0]    w_buf_cnt;
  logic [BW-1:0] w_buf_in;
  logic [BW-1:0] w_buf_out;

  // The RAM holds its outputs while mem_en is low, so an unpushed read simply
  // waits on mem_do*; a new read is issued only when the pending one is
  // guaranteed a buffer slot this cycle, giving full rate without using out_ready.
  assign w_push   = r_inflight && (w_buf_cnt != 2'd2);
  assign w_issue  = (r_state == BUSY) && (r_beats_left != '0) && (w_buf_cnt != 2'd2);
  assign w_buf_in = {mem_doa, mem_dob, r_if_bvalid, r_if_last};
  assign {out_a, out_b, out_bvalid, out_last} = w_buf_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight  <= 1'b0;
      r_if_last   <= 1'b0;
      r_if_bvalid <= 1'b0;
    end else if (w_issue) begin
      r_inflight  <= 1'b1;
      r_if_last   <= w_last_issue;
      r_if_bvalid <= w_tag_bvalid;
    end else if (w_push) begin
      r_inflight <= 1'b0;
    end
  end

  dpr_reader_outbuf #(
    .W(BW)
  ) u_outbuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_buf_in),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (w_buf_out),
    .o_count (w_buf_cnt)
  );
`else
  logic r_out_valid;
  logic r_out_last;
  logic r_out_bvalid;

  assign w_issue    = (r_state == BUSY) && (r_beats_left != '0) && (!r_out_valid || out_ready);
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign out_bvalid = r_out_bvalid;
  assign out_a      = mem_doa;
  assign out_b      = mem_dob;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_bvalid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid  <= 1'b1;
      r_out_last   <= w_last_issue;
      r_out_bvalid <= w_tag_bvalid;
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == DONE);
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = (len == '0) ? DONE : BUSY;
      BUSY:    if (w_issue && w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (w_hs && out_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_beats_left <= '0;
      r_odd        <= 1'b0;
    end else if ((r_state == IDLE) && start && (len != '0)) begin
      r_ptr        <= base_addr;
      r_beats_left <= w_beats;
      r_odd        <= len[0];
    end else if (w_issue) begin
      r_ptr        <= w_ptr_step;
      r_beats_left <= r_beats_left - BEAT_W'(1);
    end
  end

endmodule
